// File: rtl/vend_dispenser.sv
// Output back end of the vending machine: queues vend/change results and
// sequences the product motor and coin hopper through req/done handshakes.
module vend_dispenser #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out,
    input  logic [1:0] change,
    output logic       item_req,
    input  logic       item_done,
    output logic       coin_req,
    input  logic       coin_done,
    output logic       busy,
    output logic       overflow,
    output logic       bad_code,
    output logic       fault,
    output logic [7:0] coins_returned
);
    // state | meaning
    // IDLE  | waiting for a queued result
    // ITEM  | product motor requested, waiting for item_done
    // COIN  | hopper requested (or in inter-coin gap), waiting for coin_done
    typedef enum logic [1:0] {IDLE, ITEM, COIN} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    state_t        state, state_nx;
    logic [1:0]    coins_left, coins_nx;
    logic          gap, gap_nx;
    logic [TW-1:0] tmr;
    logic          pop, coin_ack, timed_out;

    logic [2:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push;
    logic [1:0]    in_coins;
    logic [2:0]    head;

    always_comb begin
        case (change)
            2'b01:   in_coins = 2'd1;
            2'b10:   in_coins = 2'd2;
            default: in_coins = 2'd0;
        endcase
    end

    assign push  = out || (in_coins != 2'd0);
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && (!full || pop))
            mem[wr_ptr[AW-1:0]] <= {out, in_coins};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            coins_left     <= 2'd0;
            gap            <= 1'b0;
            tmr            <= TW'(TIMEOUT - 1);
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overflow       <= 1'b0;
            bad_code       <= 1'b0;
            fault          <= 1'b0;
            coins_returned <= 8'd0;
        end else begin
            state      <= state_nx;
            coins_left <= coins_nx;
            gap        <= gap_nx;
            // Reload on every fresh request: state entry or end of the coin gap
            if (state_nx != state || gap)
                tmr <= TW'(TIMEOUT - 1);
            else if (tmr != '0)
                tmr <= tmr - 1'b1;
            if (push && (!full || pop))
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop)
                overflow <= 1'b1;
            if (change == 2'b11)
                bad_code <= 1'b1;
            if (timed_out)
                fault <= 1'b1;
            if (coin_ack)
                coins_returned <= coins_returned + 8'd1;
        end
    end

    always_comb begin
        state_nx  = state;
        coins_nx  = coins_left;
        gap_nx    = 1'b0;
        pop       = 1'b0;
        coin_ack  = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    coins_nx = head[1:0];
                    if (head[2])
                        state_nx = ITEM;
                    else if (head[1:0] != 2'd0)
                        state_nx = COIN;
                end
            end
            ITEM: begin
                if (item_done || tmr == '0) begin
                    timed_out = !item_done;
                    state_nx  = (coins_left != 2'd0) ? COIN : IDLE;
                end
            end
            COIN: begin
                // Done wins over a coincident timeout; done in the gap cycle is ignored
                if (!gap) begin
                    if (coin_done) begin
                        coin_ack = 1'b1;
                        coins_nx = coins_left - 2'd1;
                        if (coins_left == 2'd1)
                            state_nx = IDLE;
                        else
                            gap_nx = 1'b1;
                    end else if (tmr == '0) begin
                        timed_out = 1'b1;
                        coins_nx  = 2'd0;
                        state_nx  = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        item_req = (state == ITEM);
        coin_req = (state == COIN) && !gap;
        busy     = !empty || (state != IDLE);
    end
endmodule
